// File: rtl/stream_capture_pkg.sv
// stream_capture_pkg: sample-stream geometry shared with the source, and the capture write-state type.
package stream_capture_pkg;
  localparam int DATA_W = 9;
  localparam int FRAME_LEN = 201;
  localparam int ADDR_W = 8;
  localparam int CNT_W = 16;
  typedef enum logic {WRITE = 1'b0, DROP = 1'b1} wr_state_e;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM, one write port, synchronous read with 1-cycle latency.
module capture_ram #(
  parameter int DATA_W = 9,
  parameter int DEPTH = 402,
  parameter int AW = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/stream_capture.sv
// stream_capture: cuts the sample stream into frames and ping-pongs them between two RAM banks,
// with a random-access read port on the oldest full bank.
module stream_capture #(
  parameter int DATA_W = stream_capture_pkg::DATA_W,
  parameter int FRAME_LEN = stream_capture_pkg::FRAME_LEN,
  parameter int ADDR_W = stream_capture_pkg::ADDR_W,
  parameter int CNT_W = stream_capture_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              frame_done,
  output logic              frame_avail,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);
  import stream_capture_pkg::*;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] BANK1_BASE = (ADDR_W + 1)'(FRAME_LEN);
  wr_state_e         r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic              r_frame_done;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic              r_rd_valid;
  logic              r_rd_any;
  logic              w_rel;
  logic              w_rd_bank_n;
  logic [1:0]        w_full_rel;
  logic              w_last;
  logic              w_wr;
  logic              w_done;
  logic              w_rd;
  logic [ADDR_W:0]   w_waddr;
  logic [ADDR_W:0]   w_raddr;
  logic [DATA_W-1:0] w_ram_q;
  // Release is applied before completion so the writer can reuse a bank freed this cycle.
  assign w_rel = rd_release & r_full[r_rd_bank];
  assign w_rd_bank_n = r_rd_bank ^ w_rel;
  assign w_full_rel = r_full & ~(r_rd_bank ? {w_rel, 1'b0} : {1'b0, w_rel});
  assign w_last = in_valid & (r_wr_ptr == LAST);
  assign w_wr = in_valid & (r_state == WRITE);
  assign w_done = w_wr & w_last;
  assign w_rd = rd_en & r_full[r_rd_bank];
  assign w_waddr = {1'b0, r_wr_ptr} + (r_wr_bank ? BANK1_BASE : '0);
  assign w_raddr = {1'b0, rd_addr} + (r_rd_bank ? BANK1_BASE : '0);
  capture_ram #(.DATA_W(DATA_W), .DEPTH(2 * FRAME_LEN), .AW(ADDR_W + 1)) u_ram (
    .clk(clk),
    .i_we(w_wr),
    .i_waddr(w_waddr),
    .i_wdata(in_data),
    .i_re(w_rd),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= WRITE;
      r_wr_ptr <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full <= '0;
      r_frame_done <= 1'b0;
      r_overflow <= 1'b0;
      r_frame_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_rd_any <= 1'b0;
    end else begin
      if (in_valid) r_wr_ptr <= w_last ? '0 : r_wr_ptr + ADDR_W'(1);
      r_full <= w_full_rel | (r_wr_bank ? {w_done, 1'b0} : {1'b0, w_done});
      r_rd_bank <= w_rd_bank_n;
      r_frame_done <= w_done;
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_any <= 1'b1;
      if (w_done) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (in_valid && r_state == DROP) r_overflow <= 1'b1;
      if (w_done) begin
        if (!w_full_rel[~r_wr_bank]) r_wr_bank <= ~r_wr_bank;
        else r_state <= DROP;
      end
      // Pick the bank the reader will reach next: the one after rd_bank if it is full, else rd_bank itself.
      if (r_state == DROP && w_last && w_full_rel != 2'b11) begin
        r_state <= WRITE;
        r_wr_bank <= w_full_rel[w_rd_bank_n] ? ~w_rd_bank_n : w_rd_bank_n;
      end
    end
  end
  assign frame_done = r_frame_done;
  assign frame_avail = r_full[r_rd_bank];
  assign rd_valid = r_rd_valid;
  assign rd_data = r_rd_any ? w_ram_q : '0;
  assign overflow = r_overflow;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_stream_capture.sv
// tb_stream_capture: directed-vector bench for stream_capture with immediate-assertion checks.
module tb_stream_capture;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;
  logic        frame_done;
  logic        frame_avail;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [8:0]  rd_data;
  logic        rd_valid;
  logic        rd_release = 1'b0;
  logic        overflow;
  logic [15:0] frame_cnt;
  int total = 0;
  int bad = 0;
  int g = 0;
  int done_cnt = 0;
  int done_base;

  stream_capture dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .frame_done(frame_done), .frame_avail(frame_avail), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_on();
    cyc();
    rstn = 1'b0;
    in_valid = 1'b0;
    rd_en = 1'b0;
    rd_release = 1'b0;
    #2;
  endtask

  task automatic rst_off();
    cyc();
    rstn = 1'b1;
    g = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_avail"}, 32'(frame_avail), 0);
    chk({tag, "_rdata"}, 32'(rd_data), 0);
    chk({tag, "_rvalid"}, 32'(rd_valid), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 0);
  endtask

  task automatic send(input int n, input bit gap, input bit rel_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = 9'(g);
      rd_release = rel_last && (i == n - 1);
      g++;
      cyc();
      in_valid = 1'b0;
      rd_release = 1'b0;
      if (gap) cyc();
    end
  endtask

  task automatic rd(input int a, input string tag, input int exp);
    rd_en = 1'b1;
    rd_addr = 8'(a);
    cyc();
    rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid), 1);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    cyc();
    rd_release = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk_zero("rst");
    rst_off();
    rd_en = 1'b1;
    rd_addr = 8'd0;
    cyc();
    rd_en = 1'b0;
    chk("rd_empty_vld", 32'(rd_valid), 0);
    // single frame
    done_base = done_cnt;
    send(201, 1'b0, 1'b0);
    chk("sf_done", 32'(frame_done), 1);
    chk("sf_cnt", 32'(frame_cnt), 1);
    chk("sf_avail", 32'(frame_avail), 1);
    cyc();
    chk("sf_done_pulse", 32'(frame_done), 0);
    chk("sf_done_once", 32'(done_cnt - done_base), 1);
    rd(0, "sf_rd0", 0);
    rd(100, "sf_rd100", 100);
    rd(200, "sf_rd200", 200);
    cyc();
    chk("sf_vld_drop", 32'(rd_valid), 0);
    chk("sf_hold", 32'(rd_data), 200);
    // ping-pong then overflow
    rst_on();
    chk_zero("rst2");
    rst_off();
    send(402, 1'b0, 1'b0);
    chk("pp_cnt", 32'(frame_cnt), 2);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_avail", 32'(frame_avail), 1);
    rd(57, "pp_b0_57", 57);
    rd(200, "pp_b0_200", 200);
    send(201, 1'b0, 1'b0);
    chk("ov_flag", 32'(overflow), 1);
    chk("ov_cnt", 32'(frame_cnt), 2);
    rd(5, "ov_b0_5", 5);
    send(100, 1'b0, 1'b0);
    release_bank();
    chk("ov_avail_b1", 32'(frame_avail), 1);
    send(101, 1'b0, 1'b0);
    chk("ov_cnt_still", 32'(frame_cnt), 2);
    send(201, 1'b0, 1'b0);
    chk("ov_cnt3", 32'(frame_cnt), 3);
    rd(0, "ov_b1_0", 201);
    rd(200, "ov_b1_200", 401);
    release_bank();
    chk("ov_avail_b0", 32'(frame_avail), 1);
    rd(0, "ov_b0_new0", 292);
    rd(200, "ov_b0_new200", 492);
    // release coincident with the last sample of a dropped frame
    rst_on();
    rst_off();
    send(402, 1'b0, 1'b0);
    send(200, 1'b0, 1'b0);
    send(1, 1'b0, 1'b1);
    chk("sim_cnt_hold", 32'(frame_cnt), 2);
    send(201, 1'b0, 1'b0);
    chk("sim_cnt", 32'(frame_cnt), 3);
    chk("sim_ovf", 32'(overflow), 1);
    rd(100, "sim_b1_100", 301);
    release_bank();
    rd(0, "sim_b0_0", 91);
    rd(200, "sim_b0_200", 291);
    // gapped input
    rst_on();
    rst_off();
    done_base = done_cnt;
    send(200, 1'b1, 1'b0);
    chk("gap_cnt0", 32'(frame_cnt), 0);
    chk("gap_nodone", 32'(done_cnt - done_base), 0);
    in_valid = 1'b1;
    in_data = 9'(g);
    g++;
    cyc();
    in_valid = 1'b0;
    chk("gap_done", 32'(frame_done), 1);
    chk("gap_cnt1", 32'(frame_cnt), 1);
    rd(100, "gap_rd100", 100);
    rd(200, "gap_rd200", 200);
    // reset mid-frame
    send(57, 1'b0, 1'b0);
    rst_on();
    chk_zero("midrst");
    rst_off();
    g = 300;
    send(201, 1'b0, 1'b0);
    chk("mr_cnt", 32'(frame_cnt), 1);
    rd(0, "mr_rd0", 300);
    rd(56, "mr_rd56", 356);
    rd(200, "mr_rd200", 500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_capture.md
Name: stream_capture

Overview:
- Sink end of the sample stream: consumes the continuous valid/9-bit data stream produced by the signal source (201-sample frames, addresses 0..200 repeating).
- Cuts the stream into FRAME_LEN-sample frames and stores them in a two-bank ping-pong buffer.
- Exposes a random-access read port so the downstream DWT engine or readout logic can fetch a complete frame while the next one is being captured.
- Sits between the stimulus source and the DWT core in the FPGA test harness.

Parameters:
- DATA_W, 9, sample width
- FRAME_LEN, 201, samples per frame (must be >= 2)
- ADDR_W, 8, in-frame address width (2**ADDR_W >= FRAME_LEN)
- CNT_W, 16, frame counter width

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe from source
- in_data  in  DATA_W  sample value
- frame_done  out  1  one-cycle pulse when a frame has been fully stored
- frame_avail  out  1  at least one full bank is waiting for the reader
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  in-frame sample index (0..FRAME_LEN-1)
- rd_data  out  DATA_W  sample read from the current read bank
- rd_valid  out  1  rd_data is valid
- rd_release  in  1  reader has finished the current read bank
- overflow  out  1  sticky: at least one frame was dropped
- frame_cnt  out  CNT_W  frames stored, wraps modulo 2**CNT_W

Behaviour:
- Reset (asynchronous, rstn low): all outputs 0; wr_ptr=0; wr_bank=0; rd_bank=0; full[1:0]=0; state=WRITE. RAM contents are not reset.
- Storage: 2*FRAME_LEN words, indexed as {bank, in-frame address}. One write port, one synchronous read port.
- Write FSM, state WRITE:
  - Each cycle with in_valid=1: write in_data to {wr_bank, wr_ptr}.
  - wr_ptr increments by 1; it wraps to 0 after FRAME_LEN-1.
  - On the write at wr_ptr=FRAME_LEN-1: set full[wr_bank], pulse frame_done the next cycle, and increment frame_cnt.
  - Bank switch at that same boundary: if the other bank is not full (after applying any same-cycle release), wr_bank toggles. Otherwise the next state is DROP.
- Write FSM, state DROP:
  - Samples are counted with wr_ptr (kept frame-aligned) but not written.
  - overflow is set on the first dropped sample and stays set until reset.
  - At the wr_ptr=FRAME_LEN-1 boundary: if any bank is free, the next state is WRITE and wr_bank becomes the free bank; otherwise DROP continues.
  - A frame is never partially stored.
- in_valid low: wr_ptr holds; no write occurs.
- Read side:
  - rd_bank is always the oldest full bank.
  - frame_avail = full[rd_bank].
  - rd_en=1 while frame_avail=1: read {rd_bank, rd_addr}. rd_data and rd_valid=1 appear exactly 1 cycle later.
  - rd_en while frame_avail=0: ignored, rd_valid stays 0.
  - rd_addr >= FRAME_LEN: the returned data is undefined, but rd_valid is still asserted.
  - rd_valid is a single-cycle qualifier; rd_data holds its last value otherwise.
- Release:
  - rd_release=1 with frame_avail=1: clear full[rd_bank] and toggle rd_bank on the next cycle.
  - rd_release with frame_avail=0: ignored.
- Simultaneous events:
  - Release and frame completion in the same cycle: the release is applied first, so the writer may switch into the just-freed bank with no drop.
  - A read and a write to the same bank cannot happen (write bank != read bank while the read bank is full).
- Reset mid-frame: the partial frame is discarded. The next in_valid after reset is sample 0 of bank 0.

Decomposition:
- Shared package: DATA_W, FRAME_LEN, ADDR_W defaults (shared with the source), write-state enum {WRITE, DROP}.
- One sub-module: capture_ram — simple dual-port RAM, 2*FRAME_LEN x DATA_W, synchronous read, 1-cycle latency, inferable as block RAM.

Test Plan:
- Single frame: reset, then 201 consecutive valid samples with data=index (0..200) -> frame_done pulses once, frame_avail=1, frame_cnt=1. Reading addresses 0, 100, 200 returns 0, 100, 200, each one cycle after rd_en.
- Ping-pong: stream 402 samples with data = index mod 512 and no release -> both banks full, frame_cnt=2, overflow=0. Bank 0 reads back 0..200. After rd_release, bank 1 reads back 201..401.
- Overflow: continue streaming 201 more samples with no release -> overflow=1, frame_cnt stays 2, bank contents unchanged. Release bank 0 mid-frame; the next full frame is stored into bank 0 (frame_cnt=3).
- Simultaneous release and completion: both banks full with the writer in DROP, release exactly on the 201st sample of the dropped frame -> the next frame is captured, frame_cnt increments.
- Gapped input: in_valid toggling 1/0 for a whole frame -> identical stored data to the contiguous case, frame_done after the 201st valid sample.
- Reset mid-frame: assert rstn=0 at sample 57 -> all outputs 0. After reset, 201 samples produce frame_cnt=1 and bank 0 holds the new data.
